magnetron_ctrl: RTL

MAGNETRON_CTRL -- requirements
Module: magnetron_ctrl

---
 rtl/magnetron_ctrl_if.sv | 27 ++
 rtl/magnetron_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/magnetron_ctrl_if.sv
// Operator panel / status bundle between the oven front-end and the magnetron controller.
// master = panel side (buttons, door, programmed values); slave = controller side.
interface magnetron_ctrl_if #(
    parameter int TIME_W = 8,
    parameter int PWR_W  = 3
);
    logic              startn;
    logic              stopn;
    logic              door_closed;
    logic              load;
    logic [TIME_W-1:0] time_in;
    logic [PWR_W-1:0]  power_in;
    logic              mag_on;
    logic [TIME_W-1:0] time_left;
    logic              done;
    logic [1:0]        state;

    modport master (
        output startn, stopn, door_closed, load, time_in, power_in,
        input  mag_on, time_left, done, state
    );

    modport slave (
        input  startn, stopn, door_closed, load, time_in, power_in,
        output mag_on, time_left, done, state
    );
endinterface

// File: rtl/magnetron_ctrl.sv
// Microwave cook controller: second-tick countdown with duty-cycled magnetron power
// over a 2^PWR_W-tick window, pause/resume on door or stop, and a completion pulse.
module magnetron_ctrl #(
    parameter int TIME_W   = 8,
    parameter int TICK_DIV = 1000,
    parameter int PWR_W    = 3
) (
    input  logic             clk,
    input  logic             clearn,
    magnetron_ctrl_if.slave  bus
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COOK  = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [PWR_W-1:0]  power_q, power_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [PWR_W-1:0]  win_q, win_d;
    logic              done_q, done_d;
    logic              start_ok;

    always_ff @(posedge clk) begin
        if (!clearn) begin
            state_q <= IDLE;
            time_q  <= '0;
            power_q <= '0;
            pre_q   <= '0;
            win_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            power_q <= power_d;
            pre_q   <= pre_d;
            win_q   <= win_d;
            done_q  <= done_d;
        end
    end

    // Stop always wins over start, so a start request is only valid with stop released.
    assign start_ok = !bus.startn && bus.stopn && bus.door_closed;

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        power_d = power_q;
        pre_d   = pre_q;
        win_d   = win_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    time_d  = bus.time_in;
                    power_d = bus.power_in;
                end
                if (start_ok && (time_q != '0)) begin
                    state_d = COOK;
                    pre_d   = '0;
                    win_d   = '0;
                end
            end
            COOK: begin
                // Leaving COOK freezes everything, including a tick landing on this edge.
                if (!bus.stopn || !bus.door_closed) begin
                    state_d = PAUSE;
                end else if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    time_d = time_q - TIME_W'(1);
                    win_d  = win_q + PWR_W'(1);
                    if (time_q == TIME_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            PAUSE: begin
                if (!bus.stopn) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (start_ok) begin
                    state_d = COOK;
                end
            end
            DONE: begin
                if (!bus.stopn) begin
                    state_d = IDLE;
                end else if (bus.load) begin
                    state_d = IDLE;
                    time_d  = bus.time_in;
                    power_d = bus.power_in;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Door gating is combinational so opening the door cuts power in the same cycle.
    assign bus.mag_on    = (state_q == COOK) && bus.door_closed &&
                           ((power_q == '1) || (win_q < power_q));
    assign bus.time_left = time_q;
    assign bus.done      = done_q;
    assign bus.state     = state_q;
endmodule
